conv2_sched: RTL and testbench
==============================

Name: conv2_sched

Overview:
- Sequencing controller for the layer-2 convolution engine: 32 input channels, 64 filters, 3x3 windows.
- Walks the channel loop and issues the weight-bank base address and load strobe for each channel.
- Round-robins incoming windows across the 9 filter lanes and holds off input while weights change.
- Tags every output beat with first/last-channel flags so the downstream partial-sum accumulator knows when to clear and when to emit.
- Sits between the window generator (upstream) and the 9-lane filter array plus accumulator (downstream).

Parameters:
- CHANNEL_NUM, 32, input channels per image
- FILTER_NUM, 64, filters per lane; sets weight-bank stride
- WINDOWS_PER_CH, 285, 3x3 windows per channel (15*19)
- LANES, 9, filter lanes served round-robin
- LATENCY, 10, cycles from window acceptance to filter result
- WLOAD_CYCLES, 2, cycles the weight bank needs after wbank_load

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin one image; sampled only in IDLE
- abort  in  1  synchronous clear to IDLE
- valid_in  in  1  upstream window valid
- in_ready  out  1  controller accepts a window this cycle
- lane_load  out  9  one-hot lane capture strobe
- lane_sel  out  4  current lane index 0..8
- ch_idx  out  8  current channel
- wbank_addr  out  16  weight base = ch_idx*FILTER_NUM*9
- wbank_load  out  1  one-cycle weight fetch strobe
- out_valid  out  1  filter result valid, delayed LATENCY cycles
- out_lane  out  4  lane owning the out_valid beat
- out_first  out  1  beat belongs to channel 0; accumulator loads instead of adding
- out_last  out  1  beat belongs to channel CHANNEL_NUM-1; accumulator emits
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at image end

Behaviour:
- Reset (rst_n=0 at an edge): every output 0, state IDLE, all counters 0, tag pipeline cleared.
- abort=1 does the same as reset. abort has priority over every other event.
- States are IDLE, LOAD_W, RUN, DRAIN and DONE.
- IDLE:
  - in_ready=0.
  - start=1 moves to LOAD_W with ch_idx=0. start in any other state is ignored.
- LOAD_W:
  - wbank_load=1 in the first cycle only.
  - wbank_addr is registered and valid from that cycle.
  - Stays exactly WLOAD_CYCLES cycles, then goes to RUN.
  - lane_sel and the window counter are cleared on entry.
- RUN:
  - in_ready=1.
  - A beat is accepted when valid_in=1 and in_ready=1, in the same cycle.
  - lane_load is combinational from the accepted beat: lane_load[lane_sel]=1 in the accepting cycle, 0 otherwise.
  - On acceptance, lane_sel increments, wrapping 8 -> 0, and the window counter increments.
  - valid_in=0 means no advance; lane_sel holds.
  - The accepted beat with window counter = WINDOWS_PER_CH-1 moves to DRAIN, and in_ready drops in the next cycle.
- Tag pipeline:
  - Each accepted beat pushes {lane_sel, ch_idx==0, ch_idx==CHANNEL_NUM-1} into a LATENCY-deep shift register.
  - out_valid, out_lane, out_first and out_last appear exactly LATENCY cycles after the accepting cycle.
  - Bubbles propagate as out_valid=0.
- DRAIN:
  - in_ready=0. Waits LATENCY cycles so no beat computed with the old weights is still in flight.
  - Not last channel: increment ch_idx and go to LOAD_W.
  - Last channel: go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 from the cycle after DONE.
- Weights and ch_idx never change while any tagged beat is in flight.
- Beat counts: windows accepted per image = CHANNEL_NUM*WINDOWS_PER_CH. The default parameters give 9120 accepted windows and 9120 out_valid beats.
- Widths:
  - wbank_addr is truncated to 16 bits; the maximum at the defaults is 31*576 = 17856.
  - The window counter is 9 bits.
- Simultaneous events:
  - abort together with start in IDLE: stays in IDLE.
  - valid_in during LOAD_W or DRAIN: not accepted and not counted; upstream must hold the beat.

Test Plan:
- Reset: rst_n=0 mid-RUN with beats in flight -> next cycle busy=0, out_valid=0, ch_idx=0, no done pulse; a fresh start works normally.
- Small image, with CHANNEL_NUM=2, WINDOWS_PER_CH=4, LATENCY=3, WLOAD_CYCLES=2, start at cycle 0 and valid_in held at 1:
  - wbank_load at cycle 1 with addr 0; in_ready high in cycles 3-6.
  - lane_load one-hot lanes 0,1,2,3.
  - out_valid in cycles 6-9 with out_first=1; DRAIN.
  - wbank_load at cycle 10 with addr 576, then channel 1 beats with out_last=1.
  - done pulses exactly once.
- Lane wrap: 20 consecutive beats -> lane_sel sequence 0..8,0..8,0,1; out_lane matches, delayed LATENCY.
- Bubbles: valid_in toggling 1,0,1,0 -> only accepted beats counted, lane_sel holds on 0 cycles, out_valid shows the identical gap pattern.
- Full default image with random valid_in -> 9120 out_valid beats, out_first count 285, out_last count 285, 32 wbank_load pulses with addresses 0,576,...,17856.
- Abort and start collisions: abort during DRAIN of the last channel -> no done, returns to IDLE; start asserted during RUN -> ignored, counters unaffected.

Source files
------------

// File: rtl/conv2_sched.sv
// Channel-loop sequencer for the layer-2 convolution engine: weight-bank loads,
// round-robin lane dispatch and first/last-channel tagging of filter results.
module conv2_sched #(
  parameter int CHANNEL_NUM    = 32,
  parameter int FILTER_NUM     = 64,
  parameter int WINDOWS_PER_CH = 285,
  parameter int LANES          = 9,
  parameter int LATENCY        = 10,
  parameter int WLOAD_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             valid_in,
  output logic             in_ready,
  output logic [LANES-1:0] lane_load,
  output logic [3:0]       lane_sel,
  output logic [7:0]       ch_idx,
  output logic [15:0]      wbank_addr,
  output logic             wbank_load,
  output logic             out_valid,
  output logic [3:0]       out_lane,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int WIN_TAPS    = 9;
  localparam int ADDR_STRIDE = FILTER_NUM * WIN_TAPS;

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] lane;
    logic       first;
    logic       last;
  } tag_t;

  state_t     state_r;
  logic [8:0] win_cnt_r;
  logic [7:0] wait_cnt_r;
  tag_t       pipe_r [LATENCY];
  logic       accept_s;

  // Base of a channel's weight block; deliberately truncated to the 16-bit bus.
  function automatic logic [15:0] bank_base(input logic [7:0] ch);
    return 16'(32'(ch) * 32'(ADDR_STRIDE));
  endfunction

  // abort and reset win over a beat presented in the same cycle
  assign accept_s = in_ready & valid_in & ~abort & rst_n;

  // One-hot capture strobe for the lane that owns the accepted beat
  always_comb begin
    lane_load = '0;
    if (accept_s) begin
      lane_load = {{(LANES-1){1'b0}}, 1'b1} << lane_sel;
    end else begin
      lane_load = '0;
    end
  end

  // Channel-loop state machine with registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state_r    <= IDLE;
      in_ready   <= 1'b0;
      lane_sel   <= 4'd0;
      ch_idx     <= 8'd0;
      wbank_addr <= 16'd0;
      wbank_load <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_cnt_r  <= 9'd0;
      wait_cnt_r <= 8'd0;
    end else begin
      wbank_load <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD_W;
            busy       <= 1'b1;
            ch_idx     <= 8'd0;
            wbank_addr <= bank_base(8'd0);
            wbank_load <= 1'b1;
            lane_sel   <= 4'd0;
            win_cnt_r  <= 9'd0;
            wait_cnt_r <= 8'd0;
          end
        end
        LOAD_W: begin
          if (wait_cnt_r == 8'(WLOAD_CYCLES - 1)) begin
            state_r    <= RUN;
            in_ready   <= 1'b1;
            wait_cnt_r <= 8'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        RUN: begin
          if (accept_s) begin
            lane_sel  <= (lane_sel == 4'(LANES - 1)) ? 4'd0 : lane_sel + 4'd1;
            win_cnt_r <= win_cnt_r + 9'd1;
            if (win_cnt_r == 9'(WINDOWS_PER_CH - 1)) begin
              state_r    <= DRAIN;
              in_ready   <= 1'b0;
              wait_cnt_r <= 8'd0;
            end
          end
        end
        DRAIN: begin
          // hold weights until every beat tagged with this channel has left the array
          if (wait_cnt_r == 8'(LATENCY - 1)) begin
            wait_cnt_r <= 8'd0;
            if (ch_idx == 8'(CHANNEL_NUM - 1)) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r    <= LOAD_W;
              ch_idx     <= ch_idx + 8'd1;
              wbank_addr <= bank_base(ch_idx + 8'd1);
              wbank_load <= 1'b1;
              lane_sel   <= 4'd0;
              win_cnt_r  <= 9'd0;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Tag shift register mirroring the filter-array latency
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0].valid <= accept_s;
      pipe_r[0].lane  <= accept_s ? lane_sel : 4'd0;
      pipe_r[0].first <= accept_s & (ch_idx == 8'd0);
      pipe_r[0].last  <= accept_s & (ch_idx == 8'(CHANNEL_NUM - 1));
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign out_valid = pipe_r[LATENCY-1].valid;
  assign out_lane  = pipe_r[LATENCY-1].lane;
  assign out_first = pipe_r[LATENCY-1].first;
  assign out_last  = pipe_r[LATENCY-1].last;

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: a reduced-size instance driven from a cycle table and a
// default-size instance exercised by whole-image sequences, both scoreboarded.
module tb_conv2_sched;

  localparam int SCH = 2, SW = 4, SL = 3;
  localparam int DCH = 32, DW = 285, DL = 10;
  localparam int LN = 9, STRIDE = 576;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_start, s_abort, s_valid, d_start, d_abort, d_valid;
  logic s_in_ready, s_wbank_load, s_out_valid, s_out_first, s_out_last, s_busy, s_done;
  logic d_in_ready, d_wbank_load, d_out_valid, d_out_first, d_out_last, d_busy, d_done;
  logic [8:0]  s_lane_load, d_lane_load;
  logic [3:0]  s_lane_sel, d_lane_sel, s_out_lane, d_out_lane;
  logic [7:0]  s_ch_idx, d_ch_idx;
  logic [15:0] s_wbank_addr, d_wbank_addr;

  conv2_sched #(.CHANNEL_NUM(SCH), .WINDOWS_PER_CH(SW), .LATENCY(SL), .WLOAD_CYCLES(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .valid_in(s_valid),
    .in_ready(s_in_ready), .lane_load(s_lane_load), .lane_sel(s_lane_sel), .ch_idx(s_ch_idx),
    .wbank_addr(s_wbank_addr), .wbank_load(s_wbank_load), .out_valid(s_out_valid),
    .out_lane(s_out_lane), .out_first(s_out_first), .out_last(s_out_last),
    .busy(s_busy), .done(s_done));

  conv2_sched u_dflt (
    .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .valid_in(d_valid),
    .in_ready(d_in_ready), .lane_load(d_lane_load), .lane_sel(d_lane_sel), .ch_idx(d_ch_idx),
    .wbank_addr(d_wbank_addr), .wbank_load(d_wbank_load), .out_valid(d_out_valid),
    .out_lane(d_out_lane), .out_first(d_out_first), .out_last(d_out_last),
    .busy(d_busy), .done(d_done));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int lane; bit first; bit last; int cyc;} tag_t;

  // small-instance scoreboard
  tag_t s_q[$];
  int s_n = 0, s_wl_idx = 0, s_ov_cnt = 0, s_done_cnt = 0;
  always @(negedge clk) begin : mon_small
    tag_t t;
    if (s_out_valid) begin
      check("s_tag_pending", s_q.size() > 0, 1);
      if (s_q.size() > 0) begin
        t = s_q.pop_front();
        check("s_out_lane", s_out_lane, t.lane);
        check("s_out_first", s_out_first, t.first);
        check("s_out_last", s_out_last, t.last);
        check("s_latency", cyc - t.cyc, SL);
      end
      s_ov_cnt++;
    end
    if (s_wbank_load) begin
      check("s_wbank_addr", s_wbank_addr, (s_wl_idx * STRIDE) % 65536);
      s_wl_idx = (s_wl_idx + 1) % SCH;
    end
    if (s_done) s_done_cnt++;
    if (!rst_n || s_abort) begin
      s_q.delete(); s_n = 0; s_wl_idx = 0;
    end else if (s_in_ready) begin
      check("s_lane_sel", s_lane_sel, (s_n % SW) % LN);
      check("s_ch_idx", s_ch_idx, s_n / SW);
      if (s_valid) begin
        check("s_lane_load", s_lane_load, 32'd1 << ((s_n % SW) % LN));
        t = '{(s_n % SW) % LN, s_n < SW, s_n >= (SCH - 1) * SW, cyc};
        s_q.push_back(t);
        s_n = (s_n + 1) % (SCH * SW);
      end else begin
        check("s_lane_load_idle", s_lane_load, 0);
      end
    end else begin
      check("s_lane_load_blocked", s_lane_load, 0);
    end
  end

  // default-instance scoreboard
  tag_t d_q[$];
  int d_n = 0, d_wl_idx = 0, d_ov_cnt = 0, d_first_cnt = 0, d_last_cnt = 0;
  int d_wl_cnt = 0, d_done_cnt = 0, d_acc_total = 0;
  always @(negedge clk) begin : mon_dflt
    tag_t t;
    if (d_out_valid) begin
      check("d_tag_pending", d_q.size() > 0, 1);
      if (d_q.size() > 0) begin
        t = d_q.pop_front();
        check("d_out_lane", d_out_lane, t.lane);
        check("d_out_first", d_out_first, t.first);
        check("d_out_last", d_out_last, t.last);
        check("d_latency", cyc - t.cyc, DL);
      end
      d_ov_cnt++;
      if (d_out_first) d_first_cnt++;
      if (d_out_last) d_last_cnt++;
    end
    if (d_wbank_load) begin
      check("d_wbank_addr", d_wbank_addr, (d_wl_idx * STRIDE) % 65536);
      d_wl_idx = (d_wl_idx + 1) % DCH;
      d_wl_cnt++;
    end
    if (d_done) d_done_cnt++;
    if (!rst_n || d_abort) begin
      d_q.delete(); d_n = 0; d_wl_idx = 0;
    end else if (d_in_ready) begin
      check("d_lane_sel", d_lane_sel, (d_n % DW) % LN);
      check("d_ch_idx", d_ch_idx, d_n / DW);
      if (d_valid) begin
        check("d_lane_load", d_lane_load, 32'd1 << ((d_n % DW) % LN));
        t = '{(d_n % DW) % LN, d_n < DW, d_n >= (DCH - 1) * DW, cyc};
        d_q.push_back(t);
        d_n = (d_n + 1) % (DCH * DW);
        d_acc_total++;
      end else begin
        check("d_lane_load_idle", d_lane_load, 0);
      end
    end else begin
      check("d_lane_load_blocked", d_lane_load, 0);
    end
  end

  typedef struct {
    logic start, valid, wl; logic [15:0] addr;
    logic ir, ov, of, ol, dn, by;
  } vec_t;

  function automatic vec_t mk(input logic st, wl, input logic [15:0] a,
                              input logic ir, ov, f, l, dn, by);
    vec_t v;
    v = '{st, 1'b1, wl, a, ir, ov, f, l, dn, by};
    return v;
  endfunction

  vec_t vt[22];
  int snap_acc, snap_ov, snap_first, snap_last, snap_wl, snap_done, acc;
  bit got, tog, st_sent;

  initial begin
    // start wl addr ir ov first last done busy
    vt[0]  = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0,   0, 0, 0, 0, 0, 1);
    vt[2]  = mk(0, 0, 0,   0, 0, 0, 0, 0, 1);
    vt[3]  = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[4]  = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[5]  = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[6]  = mk(0, 0, 0,   1, 1, 1, 0, 0, 1);
    vt[7]  = mk(0, 0, 0,   0, 1, 1, 0, 0, 1);
    vt[8]  = mk(0, 0, 0,   0, 1, 1, 0, 0, 1);
    vt[9]  = mk(0, 0, 0,   0, 1, 1, 0, 0, 1);
    vt[10] = mk(0, 1, 576, 0, 0, 0, 0, 0, 1);
    vt[11] = mk(0, 0, 0,   0, 0, 0, 0, 0, 1);
    vt[12] = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[13] = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[14] = mk(0, 0, 0,   1, 0, 0, 0, 0, 1);
    vt[15] = mk(0, 0, 0,   1, 1, 0, 1, 0, 1);
    vt[16] = mk(0, 0, 0,   0, 1, 0, 1, 0, 1);
    vt[17] = mk(0, 0, 0,   0, 1, 0, 1, 0, 1);
    vt[18] = mk(0, 0, 0,   0, 1, 0, 1, 0, 1);
    vt[19] = mk(0, 0, 0,   0, 0, 0, 0, 1, 1);
    vt[20] = mk(0, 0, 0,   0, 0, 0, 0, 0, 0);
    vt[21] = mk(0, 0, 0,   0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    s_start = 0; s_abort = 0; s_valid = 0;
    d_start = 0; d_abort = 0; d_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {s_busy, d_busy}, 0);
    check("rst_in_ready", {s_in_ready, d_in_ready}, 0);
    check("rst_out_valid", {s_out_valid, d_out_valid}, 0);
    check("rst_done", {s_done, d_done}, 0);
    check("rst_ch_idx", {s_ch_idx, d_ch_idx}, 0);
    check("rst_wbank", {s_wbank_load, d_wbank_load, s_wbank_addr}, 0);
    check("rst_lane", {s_lane_sel, d_lane_sel, s_out_lane, d_out_lane}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // small image walked against the cycle table
    snap_ov = s_ov_cnt; snap_done = s_done_cnt;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      s_start = vt[i].start; s_valid = vt[i].valid;
      @(negedge clk);
      check($sformatf("tbl%0d_wbank_load", i), s_wbank_load, vt[i].wl);
      if (vt[i].wl) check($sformatf("tbl%0d_wbank_addr", i), s_wbank_addr, vt[i].addr);
      check($sformatf("tbl%0d_in_ready", i), s_in_ready, vt[i].ir);
      check($sformatf("tbl%0d_out_valid", i), s_out_valid, vt[i].ov);
      check($sformatf("tbl%0d_out_first", i), s_out_first, vt[i].of);
      check($sformatf("tbl%0d_out_last", i), s_out_last, vt[i].ol);
      check($sformatf("tbl%0d_done", i), s_done, vt[i].dn);
      check($sformatf("tbl%0d_busy", i), s_busy, vt[i].by);
    end
    @(posedge clk); #1 s_valid = 0;
    check("small_beats", s_ov_cnt - snap_ov, SCH * SW);
    check("small_done_once", s_done_cnt - snap_done, 1);

    // reset in the middle of channel 1 with beats in flight
    snap_acc = d_acc_total; snap_done = d_done_cnt; got = 0;
    @(posedge clk); #1 d_start = 1; d_valid = 1;
    @(posedge clk); #1 d_start = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk); #1;
      if (d_acc_total - snap_acc >= DW + 20) got = 1;
    end
    check("midrun_reached", got, 1);
    rst_n = 0; d_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midrun_rst_busy", d_busy, 0);
    check("midrun_rst_out_valid", d_out_valid, 0);
    check("midrun_rst_ch_idx", d_ch_idx, 0);
    repeat (15) @(posedge clk);
    check("midrun_rst_no_done", d_done_cnt - snap_done, 0);

    // full default image: lane wrap, bubbles, start while running, random valid
    snap_acc = d_acc_total; snap_ov = d_ov_cnt; snap_first = d_first_cnt;
    snap_last = d_last_cnt; snap_wl = d_wl_cnt; snap_done = d_done_cnt;
    got = 0; tog = 0; st_sent = 0;
    @(posedge clk); #1 d_start = 1;
    for (int k = 0; k < 40000 && !got; k++) begin
      @(posedge clk); #1;
      acc = d_acc_total - snap_acc;
      if (acc < 20) d_valid = 1;
      else if (acc < 24) begin tog = ~tog; d_valid = tog; end
      else d_valid = ($urandom_range(0, 3) != 0);
      if (acc == 1000 && !st_sent) begin d_start = 1; st_sent = 1; end
      else d_start = 0;
      if (d_done_cnt != snap_done) got = 1;
    end
    d_valid = 0; d_start = 0;
    check("full_done_seen", got, 1);
    @(negedge clk);
    check("full_busy_after_done", d_busy, 0);
    check("full_accepted", d_acc_total - snap_acc, DCH * DW);
    check("full_out_valid", d_ov_cnt - snap_ov, DCH * DW);
    check("full_out_first", d_first_cnt - snap_first, DW);
    check("full_out_last", d_last_cnt - snap_last, DW);
    check("full_wbank_loads", d_wl_cnt - snap_wl, DCH);
    check("full_done_once", d_done_cnt - snap_done, 1);

    // abort during DRAIN of the last channel
    snap_acc = d_acc_total; snap_done = d_done_cnt; got = 0;
    @(posedge clk); #1 d_start = 1; d_valid = 1;
    @(posedge clk); #1 d_start = 0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(posedge clk); #1;
      if (d_acc_total - snap_acc >= DCH * DW) got = 1;
    end
    check("abort_drain_reached", got, 1);
    @(posedge clk); #1 d_abort = 1;
    @(negedge clk);
    check("abort_busy_before", d_busy, 1);
    @(posedge clk); #1 d_abort = 0; d_valid = 0;
    @(negedge clk);
    check("abort_busy_after", d_busy, 0);
    check("abort_out_valid", d_out_valid, 0);
    repeat (20) @(posedge clk);
    check("abort_no_done", d_done_cnt - snap_done, 0);

    // abort and start together in IDLE
    @(posedge clk); #1 d_start = 1; d_abort = 1;
    @(posedge clk); #1 d_start = 0; d_abort = 0;
    @(negedge clk);
    check("abort_start_busy", d_busy, 0);
    check("abort_start_wbank_load", d_wbank_load, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
